// File: rtl/manchester_decoder_pkg.sv
// Shared definitions for the Manchester decoder: FSM state encodings, the
// default data width, and the bit-index counter width.
//
// Optional feature macro used by the decoder: MANCHESTER_PARITY_EN
// (adds one even-parity Manchester bit after the data bits).
package manchester_decoder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // The index counter must hold 0..16: data positions for WIDTH up to 16,
  // plus the parity slot (index == WIDTH) when parity is enabled.
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRST    = 2'd1,
    SECOND   = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

endpackage

// File: rtl/manchester_pair_check.sv
// Half-bit pair check built from NAND and inverter cells.
//
// Ports:
//   first_half  - registered first-half sample of the current bit
//   second_half - live line value during the second half
//   pair_ok     - 1 when the two halves differ (valid Manchester transition)
//   bit_val     - decoded bit value (equal to the second half)
module manchester_pair_check (
  input  logic first_half,
  input  logic second_half,
  output logic pair_ok,
  output logic bit_val
);

  wire n_ab;
  wire n_a;
  wire n_b;
  wire xor_w;
  wire second_n;
  wire bit_w;

  // Four-NAND XOR: the halves must be complements of each other.
  nand u_nand_ab (n_ab, first_half, second_half);
  nand u_nand_a  (n_a, first_half, n_ab);
  nand u_nand_b  (n_b, second_half, n_ab);
  nand u_nand_x  (xor_w, n_a, n_b);

  // The decoded bit is the second half, buffered through two inverters.
  not  u_inv_0   (second_n, second_half);
  not  u_inv_1   (bit_w, second_n);

  assign pair_ok = xor_w;
  assign bit_val = bit_w;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester line decoder. Bit b is sent as two clk cycles: ~b then b.
// The idle line is 0; a frame is a start bit (0 then 1) followed by WIDTH
// data bits, LSB first. With MANCHESTER_PARITY_EN defined, one extra
// Manchester bit carrying even parity over the data follows the data.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   a     - serial Manchester line, one half-bit per clk cycle
//   q     - last correctly decoded word (WIDTH bits)
//   valid - one-cycle pulse, q holds a new word
//   err   - one-cycle pulse, the frame was aborted
//   busy  - high while a frame is being received
module manchester_decoder
  import manchester_decoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
`ifdef MANCHESTER_PARITY_EN
  localparam logic [IDX_W-1:0] PAR_IDX = IDX_W'(WIDTH);
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               first_q, first_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               prev_q, prev_d;

  logic               pair_ok;
  logic               bit_val;

  manchester_pair_check u_pair_check (
    .first_half  (first_q),
    .second_half (a),
    .pair_ok     (pair_ok),
    .bit_val     (bit_val)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    index_d = index_q;
    shift_d = shift_q;
    q_d     = q_q;
    first_d = first_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    prev_d  = a;

    case (state_q)
      IDLE: begin
        // Start bit: rising edge on the line (prev low, now high).
        if (a && !prev_q) begin
          state_d = FIRST;
          index_d = '0;
        end
      end

      FIRST: begin
        first_d = a;
        state_d = SECOND;
      end

      SECOND: begin
        if (!pair_ok) begin
          // No mid-bit transition: abort and wait for the line to drop.
          err_d   = 1'b1;
          state_d = WAIT_LOW;
        end
`ifdef MANCHESTER_PARITY_EN
        else if (index_q == PAR_IDX) begin
          state_d = IDLE;
          if (bit_val == ^shift_q) begin
            q_d     = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (index_q == IDX_W'(i)) shift_d[i] = bit_val;
          end
          if (index_q == LAST_IDX) begin
`ifdef MANCHESTER_PARITY_EN
            index_d = index_q + 1'b1;
            state_d = FIRST;
`else
            // Load q from shift_d so the final bit lands on this edge.
            q_d     = shift_d;
            valid_d = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            index_d = index_q + 1'b1;
            state_d = FIRST;
          end
        end
      end

      WAIT_LOW: begin
        if (!a) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is reset along with the control state; it
      // is small and a known value keeps q traceable after reset.
      state_q <= IDLE;
      index_q <= '0;
      shift_q <= '0;
      q_q     <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      // prev resets high so a line held high through reset is not
      // mistaken for a start-bit edge.
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      first_q <= first_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q == FIRST) || (state_q == SECOND);

endmodule

// File: tb/tb_manchester_decoder.sv
// Self-checking bench for manchester_decoder (WIDTH = 8). Frames are driven
// one half-bit per cycle on the falling edge; expected pulses (kind, q and
// arrival cycle) are queued as each frame's deciding half-bit is driven, and
// a falling-edge monitor pops and compares them when valid or err appears.
module tb_manchester_decoder;

`ifdef MANCHESTER_PARITY_EN
  localparam int PAR_EXTRA = 2;
`else
  localparam int PAR_EXTRA = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         bad_bit;   // index of a pair sent without transition, -1 none
    logic       par_flip;  // send inverted parity (parity build only)
    logic       exp_err;
    logic [7:0] exp_q;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] q;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       a;
  logic [7:0] q;
  logic       valid;
  logic       err;
  logic       busy;

  int   n_run;
  int   n_fail;
  int   cyc;
  exp_t sb_q[$];
  vec_t vecs[$];

  manchester_decoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .q     (q),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid/err pulse must match the oldest
  // queued expectation.
  always @(negedge clk) begin
    if (valid || err) begin
      check("valid_err_exclusive", {31'b0, valid & err}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, valid, err}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_is_err", {31'b0, err}, {31'b0, e.is_err});
        check("pulse_q", {24'b0, q}, {24'b0, e.q});
        check("pulse_cycle", cyc, e.due);
      end
    end
  end

  task automatic half(input logic v);
    @(negedge clk);
    a = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) half(1'b0);
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] eq, input int due);
    exp_t e;
    e.is_err = is_err;
    e.q      = eq;
    e.due    = due;
    sb_q.push_back(e);
  endtask

  // Sends start bit + 8 data bits (+ parity in the parity build). A pair at
  // bad_bit is sent as d,d (no transition) and aborts the frame there.
  task automatic send_frame(input logic [7:0] d, input int bad_bit, input logic par_flip,
                            input logic exp_err, input logic [7:0] exp_q);
    int   t0;
    logic aborted;
    logic p;
    aborted = 1'b0;
    half(1'b0);
    half(1'b1);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (!aborted) begin
        if (i == bad_bit) begin
          half(d[i]);
          half(d[i]);
          push_exp(exp_err, exp_q, t0 + 2 * i + 3);
          aborted = 1'b1;
        end else begin
          half(~d[i]);
          if (i == 0) check("busy_in_frame", {31'b0, busy}, 32'd1);
          half(d[i]);
          if (i == 7 && PAR_EXTRA == 0) push_exp(exp_err, exp_q, t0 + 17);
        end
      end
    end
`ifdef MANCHESTER_PARITY_EN
    if (!aborted) begin
      p = (^d) ^ par_flip;
      half(~p);
      half(p);
      push_exp(exp_err, exp_q, t0 + 17 + PAR_EXTRA);
    end
`else
    p = par_flip;
`endif
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    cyc    = 0;
    a      = 1'b0;
    rst    = 1'b1;

    vecs.push_back('{data: 8'hA5, bad_bit: -1, par_flip: 1'b0, exp_err: 1'b0, exp_q: 8'hA5});
    vecs.push_back('{data: 8'h3C, bad_bit: 4,  par_flip: 1'b0, exp_err: 1'b1, exp_q: 8'hA5});
    vecs.push_back('{data: 8'h5A, bad_bit: -1, par_flip: 1'b0, exp_err: 1'b0, exp_q: 8'h5A});
    vecs.push_back('{data: 8'h80, bad_bit: 7,  par_flip: 1'b0, exp_err: 1'b1, exp_q: 8'h5A});
    vecs.push_back('{data: 8'hC3, bad_bit: 0,  par_flip: 1'b0, exp_err: 1'b1, exp_q: 8'h5A});
    vecs.push_back('{data: 8'h12, bad_bit: 2,  par_flip: 1'b0, exp_err: 1'b1, exp_q: 8'h5A});
    vecs.push_back('{data: 8'hFF, bad_bit: -1, par_flip: 1'b0, exp_err: 1'b0, exp_q: 8'hFF});
    vecs.push_back('{data: 8'h00, bad_bit: -1, par_flip: 1'b0, exp_err: 1'b0, exp_q: 8'h00});
`ifdef MANCHESTER_PARITY_EN
    vecs.push_back('{data: 8'h07, bad_bit: -1, par_flip: 1'b0, exp_err: 1'b0, exp_q: 8'h07});
    vecs.push_back('{data: 8'h07, bad_bit: -1, par_flip: 1'b1, exp_err: 1'b1, exp_q: 8'h07});
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_q", {24'b0, q}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    idle(3);

    // Table-driven frames with an idle gap after each.
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].bad_bit, vecs[k].par_flip,
                 vecs[k].exp_err, vecs[k].exp_q);
      idle(4);
      check("idle_after_frame_busy", {31'b0, busy}, 32'd0);
    end

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, -1, 1'b0, 1'b0, 8'h01);
    send_frame(8'hFE, -1, 1'b0, 1'b0, 8'hFE);
    idle(4);
    check("b2b_final_q", {24'b0, q}, 32'hFE);

    // Reset in the middle of a 0x55 frame: no pulse, q cleared.
    half(1'b0);
    half(1'b1);
    for (int i = 0; i < 4; i++) begin
      half(~(8'h55 >> i) & 1'b1);
      half((8'h55 >> i) & 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a   = 1'b0;
    check("midreset_valid", {31'b0, valid}, 32'd0);
    check("midreset_err", {31'b0, err}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_q", {24'b0, q}, 32'd0);
    idle(3);
    send_frame(8'h66, -1, 1'b0, 1'b0, 8'h66);
    idle(4);

    // Line held high through and after reset: no spurious start.
    @(negedge clk);
    a   = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("held_high_busy", {31'b0, busy}, 32'd0);
    check("held_high_q", {24'b0, q}, 32'd0);
    send_frame(8'h81, -1, 1'b0, 1'b0, 8'h81);
    idle(4);
    check("held_high_final_q", {24'b0, q}, 32'h81);

    // Bounded wait for any outstanding expectations.
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
